hram_rw_scheduler: RTL

HRAM_RW_SCHEDULER -- requirements
Module: hram_rw_scheduler

---
 rtl/hram_rw_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hram_rw_scheduler.sv
// HyperRAM read/write burst scheduler.
// Arbitrates UART weight-load writes against LSTM weight-stream reads.
// Each burst is issued to the controller, and the scheduler waits for its
// data beats, with a watchdog in case they stop. An idle gap follows every burst.
//
// Handshake: a requester holds its req high until it sees its done pulse, and
// drops req on the cycle after done. The length is captured on the grant edge.
// The grant stays high from the first BURST cycle through the done cycle.
// hram_data_valid marks one transferred word per cycle and counts only in BURST.
module hram_rw_scheduler #(
    parameter int LEN_W       = 21,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk_200m,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [LEN_W-1:0] wr_len,
    output logic             wr_grant,
    output logic             wr_done,
    input  logic             rd_req,
    input  logic [LEN_W-1:0] rd_len,
    output logic             rd_grant,
    output logic             rd_done,
    output logic             hram_start,
    output logic             hram_w_r,
    output logic [31:0]      hram_length,
    input  logic             hram_data_valid,
    output logic             busy,
    output logic             err_timeout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t             state, state_n;
    logic [LEN_W-1:0]   cnt, cnt_n;       // words transferred in this burst
    logic [LEN_W-1:0]   len_q, len_n;     // length latched at grant
    logic [WD_W-1:0]    wd, wd_n;         // cycles since last progress
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               dir_q, dir_n;     // 1 = read burst
    logic               last_wr, last_wr_n;
    logic               grant_q, grant_n;
    logic               start_q, start_n;
    logic               done_q, done_n;
    logic               tmo_q, tmo_n;
    logic               pick_rd;
    logic [LEN_W-1:0]   sel_len;

    // Round-robin pick: on a tie, serve the direction not served last.
    always_comb begin
        pick_rd = rd_req && (!wr_req || last_wr);
        sel_len = pick_rd ? rd_len : wr_len;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        len_n     = len_q;
        wd_n      = wd;
        gap_n     = gap_cnt;
        dir_n     = dir_q;
        last_wr_n = last_wr;
        grant_n   = grant_q;
        start_n   = 1'b0;
        done_n    = 1'b0;
        tmo_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_req || rd_req) begin
                    state_n   = S_BURST;
                    dir_n     = pick_rd;
                    last_wr_n = !pick_rd;
                    len_n     = sel_len;
                    cnt_n     = '0;
                    wd_n      = WD_W'(1);
                    grant_n   = 1'b1;
                    // A zero-length burst never reaches the controller.
                    if (sel_len == '0) done_n = 1'b1;
                    else               start_n = 1'b1;
                end
            end
            S_BURST: begin
                if (done_q) begin
                    // Done cycle: release the port on the following edge.
                    state_n = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    grant_n = 1'b0;
                    gap_n   = '0;
                end else if (hram_data_valid) begin
                    wd_n  = WD_W'(1);
                    cnt_n = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) done_n = 1'b1;
                end else begin
                    wd_n = wd + WD_W'(1);
                    if (wd >= WD_LIMIT) begin
                        done_n = 1'b1;
                        tmo_n  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_IDLE;
                else                     gap_n   = gap_cnt + GAP_W'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers; reset returns to IDLE with last-served = write.
    always_ff @(posedge clk_200m) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            len_q   <= '0;
            wd      <= '0;
            gap_cnt <= '0;
            dir_q   <= 1'b0;
            last_wr <= 1'b1;
            grant_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            len_q   <= len_n;
            wd      <= wd_n;
            gap_cnt <= gap_n;
            dir_q   <= dir_n;
            last_wr <= last_wr_n;
            grant_q <= grant_n;
            start_q <= start_n;
            done_q  <= done_n;
            tmo_q   <= tmo_n;
        end
    end

    // Output decode from registered state; one grant bit, split by direction.
    always_comb begin
        wr_grant    = grant_q && !dir_q;
        rd_grant    = grant_q && dir_q;
        wr_done     = done_q && !dir_q;
        rd_done     = done_q && dir_q;
        hram_start  = start_q;
        hram_w_r    = dir_q;
        hram_length = 32'(len_q);
        busy        = (state != S_IDLE);
        err_timeout = tmo_q;
        dbg_state   = state;
    end

endmodule
